imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_ext_unit.sv | 23 ++
 rtl/imm_ext_arbiter.sv | 107 ++++++++++
 tb/tb_imm_ext_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Immediate-extension definitions shared by decode and the extension arbiter.
// Holds the mode encoding and the datapath widths.
package imm_ext_pkg;

  localparam int EXT_W  = 32;
  localparam int IMM_W  = 11;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    EXT_ZEXT8  = 2'd0,
    EXT_SEXT8  = 2'd1,
    EXT_SEXT11 = 2'd2,
    EXT_ZEXT11 = 2'd3
  } ext_mode_e;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational 8/11-bit to 32-bit immediate extender.
// SEXT11 replicates bit 10; the 8-bit modes ignore imm[10:8].
module imm_ext_unit
  import imm_ext_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  input  logic [IMM_W-1:0]  imm,
  output logic [EXT_W-1:0]  ext
);

  // Mode-selected zero or sign extension
  always_comb begin
    ext = '0;
    case (mode)
      EXT_ZEXT8:  ext = {24'd0, imm[7:0]};
      EXT_SEXT8:  ext = {{24{imm[7]}}, imm[7:0]};
      EXT_SEXT11: ext = {{21{imm[10]}}, imm[10:0]};
      EXT_ZEXT11: ext = {21'd0, imm[10:0]};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender among the issue slots,
// with a registered valid/ready result tagged by the winning slot index.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int N_SLOTS = 2,
  parameter int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SLOTS-1:0]          req_valid,
  input  logic [N_SLOTS*IMM_W-1:0]    req_imm,
  input  logic [N_SLOTS*MODE_W-1:0]   req_mode,
  output logic [N_SLOTS-1:0]          req_ready,
  output logic                        out_valid,
  output logic [EXT_W-1:0]            out_data,
  output logic [SLOT_W-1:0]           out_slot,
  input  logic                        out_ready
);

  logic [SLOT_W-1:0]  rr_ptr_r;
  logic [SLOT_W-1:0]  grant_idx_s;
  logic [SLOT_W-1:0]  next_ptr_s;
  logic               grant_any_s;
  logic               take_s;
  logic               can_accept_s;
  logic               fire_s;
  logic [N_SLOTS-1:0] req_ready_s;
  logic [IMM_W-1:0]   sel_imm_s;
  logic [MODE_W-1:0]  sel_mode_s;
  logic [EXT_W-1:0]   ext_s;
  logic               out_valid_r;
  logic [EXT_W-1:0]   out_data_r;
  logic [SLOT_W-1:0]  out_slot_r;
  int                 off_s;
  int                 best_off_s;

  assign can_accept_s = ~out_valid_r | out_ready;

  // Pick the requester with the smallest rotational distance from rr_ptr
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    best_off_s  = N_SLOTS;
    off_s       = 0;
    take_s      = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      off_s       = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i + N_SLOTS - int'(rr_ptr_r));
      take_s      = req_valid[i] & (off_s < best_off_s);
      best_off_s  = take_s ? off_s : best_off_s;
      grant_idx_s = take_s ? SLOT_W'(i) : grant_idx_s;
      grant_any_s = grant_any_s | take_s;
    end
  end

  // One-hot grant, suppressed while stalled or in reset
  always_comb begin
    req_ready_s = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      req_ready_s[i] = ~reset & can_accept_s & grant_any_s & (grant_idx_s == SLOT_W'(i));
    end
  end

  // Operand mux feeding the single shared extender
  always_comb begin
    sel_imm_s  = '0;
    sel_mode_s = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      sel_imm_s  = (grant_idx_s == SLOT_W'(i)) ? req_imm[IMM_W*i +: IMM_W]   : sel_imm_s;
      sel_mode_s = (grant_idx_s == SLOT_W'(i)) ? req_mode[MODE_W*i +: MODE_W] : sel_mode_s;
    end
  end

  imm_ext_unit u_ext (
    .mode (sel_mode_s),
    .imm  (sel_imm_s),
    .ext  (ext_s)
  );

  assign fire_s     = |req_ready_s;
  assign next_ptr_s = (grant_idx_s == SLOT_W'(N_SLOTS - 1)) ? '0 : (grant_idx_s + SLOT_W'(1));

  // Result register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_slot_r  <= '0;
      rr_ptr_r    <= '0;
    end else if (fire_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= ext_s;
      out_slot_r  <= grant_idx_s;
      rr_ptr_r    <= next_ptr_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_slot  = out_slot_r;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboard bench for imm_ext_arbiter (N_SLOTS=3): a spec-level model predicts
// grants and extended results; a negedge monitor checks the result stream.
module tb_imm_ext_arbiter;

  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*11-1:0] req_imm;
  logic [N*2-1:0]  req_mode;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [31:0]     out_data;
  logic [SW-1:0]   out_slot;
  logic            out_ready;

  bit              vld_a [N];
  logic [10:0]     imm_a [N];
  logic [1:0]      mode_a[N];

  typedef struct {
    logic [31:0] data;
    int          slot;
  } res_t;

  res_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   m_ptr  = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_imm   = '0;
    req_mode  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = vld_a[i];
      req_imm[11*i +: 11] = imm_a[i];
      req_mode[2*i +: 2]  = mode_a[i];
    end
  end

  imm_ext_arbiter #(.N_SLOTS(N), .SLOT_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_imm   (req_imm),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_slot  (out_slot),
    .out_ready (out_ready)
  );

  // Extension rules expressed as integer arithmetic on the immediate value
  function automatic logic [31:0] model_ext(input int mode, input int imm);
    int v;
    case (mode)
      0:       v = imm % 256;
      1:       v = ((imm % 256) >= 128) ? (imm % 256) - 256 : (imm % 256);
      2:       v = (imm >= 1024) ? imm - 2048 : imm;
      default: v = imm;
    endcase
    return 32'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vld(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) vld_a[i] = v[i];
  endtask

  // Predict the grant for the current inputs, check req_ready, then clock once
  task automatic step();
    int          g;
    logic [31:0] exp_r;
    #1;
    g = -1;
    if (!reset && ((q.size() == 0) || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && vld_a[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_r = (g >= 0) ? (32'd1 << g) : 32'd0;
    check("req_ready", 32'(req_ready), exp_r);
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_ptr  = 0;
      mon_en = 1'b1;
    end else if (g >= 0) begin
      q.push_back('{model_ext(int'(mode_a[g]), int'(imm_a[g])), g});
      m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  // Monitor: the head of the queue is what the result register must show
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        check("out_data", out_data, q[0].data);
        check("out_slot", 32'(out_slot), 32'(q[0].slot));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      imm_a[i]  = 11'(i * 37);
      mode_a[i] = 2'(i);
    end
    set_vld(3'b111);
    step();
    step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_slot", 32'(out_slot), 32'd0);

    // Release with every slot requesting: slot 0 wins first
    reset = 1'b0;
    step();
    set_vld(3'b000);
    step();
    step();

    // The four extension modes on slot 0, back to back
    for (int m = 0; m < 4; m++) begin
      set_vld(3'b001);
      imm_a[0]  = (m < 2) ? 11'h0F5 : 11'h4F5;
      mode_a[0] = 2'(m);
      step();
    end
    set_vld(3'b000);
    step();

    // Fairness between slots 0 and 1
    set_vld(3'b011);
    repeat (4) step();
    set_vld(3'b000);
    step();
    step();

    // Backpressure: pending result held while slot 1 waits
    set_vld(3'b001);
    step();
    out_ready = 1'b0;
    set_vld(3'b010);
    imm_a[1]  = 11'h7AB;
    mode_a[1] = 2'd2;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    set_vld(3'b000);
    step();
    step();

    // Pointer wrap: slot 2 alone, then slots 0 and 1 together
    set_vld(3'b100);
    step();
    set_vld(3'b011);
    step();
    step();
    set_vld(3'b000);
    step();

    // Reset while a result is stalled: it must never be delivered
    set_vld(3'b001);
    step();
    out_ready = 1'b0;
    set_vld(3'b000);
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    set_vld(3'b011);
    step();
    set_vld(3'b000);
    step();

    // Randomized traffic with occasional stalls and resets
    for (int c = 0; c < 3000; c++) begin
      set_vld(3'($urandom_range(0, 7)));
      for (int i = 0; i < N; i++) begin
        imm_a[i]  = 11'($urandom_range(0, 2047));
        mode_a[i] = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end

    reset     = 1'b0;
    out_ready = 1'b1;
    set_vld(3'b000);
    step();
    step();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
